// File: rtl/instr_loader_if.sv
// Load-port bundle: byte stream into the loader and write bus out to instruction memory.
// master = loader side, slave = byte source / memory side.
interface instr_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [DATA_W/2-1:0] byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic [DATA_W-1:0]   instruction_in;
  logic [ADDR_W-1:0]   instruction_add;
  logic                write_enable;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, instruction_in, instruction_add, write_enable
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, instruction_in, instruction_add, write_enable
  );
endinterface

// File: rtl/instr_loader.sv
// Packs a high-byte-first byte stream into instructions and writes them to
// consecutive instruction memory addresses, halting the CPU during the load.
module instr_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  instr_loader_if.master    bus,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   words_written
);
  localparam int BYTE_W = DATA_W / 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HI, ST_LO, ST_WRITE, ST_DONE, ST_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   add_q, add_d;
  logic                ready;
  logic                hs;

  assign ready = (state_q == ST_HI) || (state_q == ST_LO);
  assign hs    = bus.byte_valid && ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    instr_d = instr_q;
    add_d   = add_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = load_len;
          words_d = '0;
          addr_d  = '0;
          state_d = (load_len == '0) ? ST_DONE : ST_HI;
        end
      end
      ST_HI: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (hs) begin
          hi_d    = bus.byte_in;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        // The bus registers only change as the strobe rises, so they hold between writes.
        if (abort) begin
          state_d = ST_ABORT;
        end else if (hs) begin
          instr_d = {hi_q, bus.byte_in};
          add_d   = addr_q;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The strobe is already out this cycle, so the word counts even if aborted.
        words_d = words_q + 1'b1;
        if (abort) begin
          state_d = ST_ABORT;
        end else if (words_q + 1'b1 == len_q) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_HI;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      instr_q <= '0;
      add_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      instr_q <= instr_d;
      add_q   <= add_d;
    end
  end

  assign bus.byte_ready      = ready;
  assign bus.write_enable    = (state_q == ST_WRITE);
  assign bus.instruction_in  = instr_q;
  assign bus.instruction_add = add_q;
  assign cpu_halt            = (state_q != ST_IDLE);
  assign busy                = (state_q != ST_IDLE);
  assign done                = (state_q == ST_DONE);
  assign aborted             = (state_q == ST_ABORT);
  assign words_written       = words_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: drives the byte stream and records every
// memory write, done and aborted pulse for comparison with hand-computed values.
module tb_instr_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] load_len = '0;
  logic       abort = 1'b0;
  logic       cpu_halt, busy, done, aborted;
  logic [8:0] words_written;

  instr_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  instr_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .load_len      (load_len),
    .abort         (abort),
    .bus           (bus.master),
    .cpu_halt      (cpu_halt),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [15:0] wr_data [0:1023];
  logic [7:0]  wr_addr [0:1023];
  int          wr_cyc  [0:1023];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          ab_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.write_enable && wr_cnt < 1024) begin
      wr_data[wr_cnt] = bus.instruction_in;
      wr_addr[wr_cnt] = bus.instruction_add;
      wr_cyc[wr_cnt]  = cyc;
      $display("write #%0d addr=%0d data=%04h", wr_cnt, bus.instruction_add, bus.instruction_in);
      wr_cnt = wr_cnt + 1;
    end
    if (done)    done_cnt = done_cnt + 1;
    if (aborted) ab_cnt = ab_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("ready_timeout", 0, 1);
      bus.byte_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic gap();
    int n = $urandom_range(0, 2);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [8:0] len);
    load_len = len;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Waits for done, then checks that cpu_halt is high with it and low one cycle later.
  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      chk({tag, "_done_timeout"}, 0, 1);
    end else begin
      chk({tag, "_halt_in_done"}, cpu_halt, 1);
      @(negedge clk);
      chk({tag, "_halt_after"}, cpu_halt, 0);
      chk({tag, "_done_width"}, done, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.byte_ready, 0);
    chk({tag, "_we"}, bus.write_enable, 0);
    chk({tag, "_instr"}, bus.instruction_in, 0);
    chk({tag, "_add"}, bus.instruction_add, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_halt"}, cpu_halt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words"}, words_written, 0);
  endtask

  initial begin
    int wb, db, ab;
    logic [7:0] h, l;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Basic load: two words, valid held high.
    wb = wr_cnt; db = done_cnt;
    do_start(9'd2);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    bus.byte_valid = 1'b0;
    wait_done("basic");
    chk("basic_nwr", wr_cnt - wb, 2);
    chk("basic_d0", wr_data[wb], 16'h1234);
    chk("basic_a0", wr_addr[wb], 0);
    chk("basic_d1", wr_data[wb+1], 16'hABCD);
    chk("basic_a1", wr_addr[wb+1], 1);
    chk("basic_space", wr_cyc[wb+1] - wr_cyc[wb], 3);
    chk("basic_ndone", done_cnt - db, 1);
    chk("basic_words", words_written, 2);

    // Zero length: DONE straight away, no writes.
    wb = wr_cnt;
    do_start(9'd0);
    chk("zero_done", done, 1);
    chk("zero_ready", bus.byte_ready, 0);
    chk("zero_words", words_written, 0);
    @(negedge clk);
    chk("zero_busy", busy, 0);
    chk("zero_nwr", wr_cnt - wb, 0);

    // Full memory with random stalls.
    wb = wr_cnt;
    do_start(9'd256);
    for (int i = 0; i < 256; i++) begin
      h = i[7:0];
      l = i[7:0] ^ 8'h5A;
      gap(); send_byte(h);
      gap(); send_byte(l);
    end
    bus.byte_valid = 1'b0;
    wait_done("full");
    chk("full_nwr", wr_cnt - wb, 256);
    for (int i = 0; i < 256; i++) begin
      h = i[7:0];
      l = i[7:0] ^ 8'h5A;
      chk("full_data", wr_data[wb+i], {h, l});
      chk("full_addr", wr_addr[wb+i], i);
    end
    chk("full_last_add", bus.instruction_add, 255);
    chk("full_words", words_written, 256);

    // Abort while waiting for the low byte of word 4.
    wb = wr_cnt; ab = ab_cnt; db = done_cnt;
    do_start(9'd4);
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    send_byte(8'h77);
    bus.byte_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    @(negedge clk);
    chk("abort_width", aborted, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nwr", wr_cnt - wb, 3);
    chk("abort_nab", ab_cnt - ab, 1);
    chk("abort_ndone", done_cnt - db, 0);
    chk("abort_words", words_written, 3);
    chk("abort_d2", wr_data[wb+2], 16'h0506);
    wb = wr_cnt;
    do_start(9'd1);
    send_byte(8'hBE); send_byte(8'hEF);
    bus.byte_valid = 1'b0;
    wait_done("after_abort");
    chk("after_abort_nwr", wr_cnt - wb, 1);
    chk("after_abort_d", wr_data[wb], 16'hBEEF);
    chk("after_abort_a", wr_addr[wb], 0);

    // Reset asserted during the WRITE cycle of word 2.
    db = done_cnt; ab = ab_cnt;
    do_start(9'd4);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    bus.byte_valid = 1'b0;
    chk("rstmid_in_write", bus.write_enable, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rstmid");
    wb = wr_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_nwr", wr_cnt - wb, 0);
    chk("rstmid_ndone", done_cnt - db, 0);
    chk("rstmid_nab", ab_cnt - ab, 0);

    // start pulsed mid-load must be ignored.
    wb = wr_cnt; db = done_cnt;
    do_start(9'd2);
    send_byte(8'hC0); send_byte(8'hDE);
    load_len = 9'd5;
    start    = 1'b1;
    send_byte(8'hF0);
    start    = 1'b0;
    send_byte(8'h0D);
    bus.byte_valid = 1'b0;
    wait_done("busy_start");
    repeat (3) @(negedge clk);
    chk("busy_start_nwr", wr_cnt - wb, 2);
    chk("busy_start_ndone", done_cnt - db, 1);
    chk("busy_start_words", words_written, 2);
    chk("busy_start_d1", wr_data[wb+1], 16'hF00D);
    chk("busy_start_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
